// File: rtl/fib_arb_ctrl.sv
// fib_arb_ctrl: round-robin arbiter feeding an iterative 11-bit Fibonacci engine.
// Define FIB_SAT_EN to saturate n at 2047 instead of wrapping.
module fib_arb_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [4:0]  steps0,
  input  logic        req1,
  input  logic [4:0]  steps1,
  input  logic        selector,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [10:0] m,
  output logic [10:0] n,
  output logic [10:0] x,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t      state_q;
  logic        ptr_q, id_q, sel_q, ovf_q, gnt0_q, gnt1_q, busy_q, done_q, done_id_q;
  logic [4:0]  steps_q, cnt_q;
  logic [10:0] m_q, n_q, n_d;
  logic [11:0] sum;
  logic        win;
  assign sum = {1'b0, m_q} + {1'b0, n_q};
  assign win = (req0 & req1) ? ptr_q : req1;
`ifdef FIB_SAT_EN
  assign n_d = sum[11] ? 11'h7ff : sum[10:0];
`else
  assign n_d = sum[10:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      sel_q     <= 1'b0;
      steps_q   <= '0;
      cnt_q     <= '0;
      m_q       <= '0;
      n_q       <= '0;
      ovf_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      case (state_q)
        IDLE: if (req0 | req1) begin
          state_q <= LOAD;
          id_q    <= win;
          steps_q <= win ? steps1 : steps0;
          sel_q   <= selector;
          ptr_q   <= ~win;
          gnt0_q  <= ~win;
          gnt1_q  <= win;
          busy_q  <= 1'b1;
        end
        LOAD: begin
          m_q   <= {10'd0, sel_q};
          n_q   <= sel_q ? 11'd2 : 11'd1;
          ovf_q <= 1'b0;
          cnt_q <= steps_q;
          state_q <= (steps_q == 5'd0) ? DONE : RUN;
          done_q    <= steps_q == 5'd0;
          done_id_q <= (steps_q == 5'd0) & id_q;
        end
        RUN: begin
          m_q   <= n_q;
          n_q   <= n_d;
          ovf_q <= ovf_q | sum[11];
          cnt_q <= cnt_q - 5'd1;
          state_q   <= (cnt_q == 5'd1) ? DONE : RUN;
          done_q    <= cnt_q == 5'd1;
          done_id_q <= (cnt_q == 5'd1) & id_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign m       = m_q;
  assign n       = n_q;
  assign x       = m_q + n_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_fib_arb_ctrl.sv
// tb_fib_arb_ctrl: scoreboard bench for fib_arb_ctrl; completed jobs are matched against queued expectations.
module tb_fib_arb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, selector = 1'b0;
  logic [4:0]  steps0 = '0, steps1 = '0;
  logic        gnt0, gnt1, busy, done, done_id, ovf;
  logic [10:0] m, n, x;
  int          checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic        id;
    logic [10:0] m;
    logic [10:0] n;
    logic        ovf;
    int          due;
  } exp_t;
  exp_t sbq[$];
  exp_t got_e;

  fib_arb_ctrl dut (
    .clk(clk), .rst(rst), .req0(req0), .steps0(steps0), .req1(req1), .steps1(steps1),
    .selector(selector), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .m(m), .n(n), .x(x), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [10:0] em, input logic [10:0] en,
                              input logic eo, input int due);
    exp_t e;
    e.id = id; e.m = em; e.n = en; e.ovf = eo; e.due = due;
    return e;
  endfunction

  always @(negedge clk) if (done) begin
    if (sbq.size() == 0) chk("spurious_done", 1, 0);
    else begin
      got_e = sbq.pop_front();
      chk("done_id", done_id, got_e.id);
      chk("m", m, got_e.m);
      chk("n", n, got_e.n);
      chk("x", x, 32'(11'(got_e.m + got_e.n)));
      chk("ovf", ovf, got_e.ovf);
      chk("done_cyc", cyc, got_e.due);
      chk("busy_in_done", busy, 1);
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 80) chk("idle_timeout", 0, 1);
  endtask

  task automatic job(input logic id, input logic [4:0] st, input logic sel,
                     input logic [10:0] em, input logic [10:0] en, input logic eo);
    if (id) begin req1 = 1'b1; steps1 = st; end
    else begin req0 = 1'b1; steps0 = st; end
    selector = sel;
    sbq.push_back(mk(id, em, en, eo, cyc + int'(st) + 2));
    @(negedge clk);
    chk("gnt0", gnt0, !id);
    chk("gnt1", gnt1, id);
    chk("busy_load", busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    selector = 1'b0;
    wait_idle();
  endtask

  initial begin
    int d, k;
    logic [10:0] sat_n;
`ifdef FIB_SAT_EN
    sat_n = 11'd2047;
`else
    sat_n = 11'd536;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_done", {done, done_id}, 0);
    chk("rst_mnx", {m, n, x}, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    job(1'b0, 5'd10, 1'b0, 11'd55, 11'd89, 1'b0);
    job(1'b1, 5'd5, 1'b1, 11'd13, 11'd21, 1'b0);
    job(1'b0, 5'd17, 1'b0, 11'd1597, sat_n, 1'b1);
    repeat (2) @(negedge clk);
    chk("hold_m", m, 1597);
    chk("hold_n", n, sat_n);
    chk("hold_ovf", ovf, 1);
    job(1'b0, 5'd0, 1'b0, 11'd0, 11'd1, 1'b0);
    // Both held through reset: pointer restarts at 0, so 0,1,0.
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; steps0 = 5'd2; steps1 = 5'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d = cyc;
    sbq.push_back(mk(1'b0, 11'd1, 11'd2, 1'b0, d + 4));
    sbq.push_back(mk(1'b1, 11'd2, 11'd3, 1'b0, d + 10));
    sbq.push_back(mk(1'b0, 11'd1, 11'd2, 1'b0, d + 15));
    for (int g = 0; g < 3; g++) begin
      for (k = 0; k < 30; k++) begin
        @(negedge clk);
        if (gnt0 | gnt1) break;
      end
      if (k == 30) chk("arb_timeout", 0, 1);
      chk("arb_gnt0", gnt0, g != 1);
      chk("arb_gnt1", gnt1, g == 1);
      chk("arb_gnt_cyc", cyc, d + (g == 0 ? 1 : g == 1 ? 6 : 12));
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    // Abort mid-RUN: no done may follow.
    req0 = 1'b1; steps0 = 5'd10;
    @(negedge clk);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {gnt0, gnt1, done, done_id, ovf}, 0);
    chk("abort_mnx", {m, n, x}, 0);
    repeat (15) @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
